// File: rtl/ss_seq_pkg.sv
// Shared types and helpers for the iteration sequencer: FSM state, completion status, width helper.
package ss_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    REQ  = 2'b10,
    DONE = 2'b11
  } ss_seq_state_e;

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_TMO   = 2'b01,
    ST_ABORT = 2'b10
  } ss_seq_status_e;

  // Width for a counter holding 0..v-1, never narrower than one bit.
  function automatic int unsigned min1_clog2(input int unsigned v);
    return ($clog2(v) > 0) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/ss_iter_sequencer_if.sv
// Start/abort/step handshake bundle between the sequencer and its datapath/control environment.
interface ss_iter_sequencer_if
  import ss_seq_pkg::*;
#(
  parameter int unsigned IDX_W = 5
);

  logic           i_start;
  logic           i_abort;
  logic           i_step_ack;
  logic           o_load;
  logic           o_step_req;
  logic [IDX_W-1:0] o_iter_idx;
  logic           o_busy;
  logic           o_done;
  ss_seq_status_e o_status;

  // Sequencer side.
  modport master (
    input  i_start,
    input  i_abort,
    input  i_step_ack,
    output o_load,
    output o_step_req,
    output o_iter_idx,
    output o_busy,
    output o_done,
    output o_status
  );

  // Environment side: start detector, abort source and iterative datapath.
  modport slave (
    output i_start,
    output i_abort,
    output i_step_ack,
    input  o_load,
    input  o_step_req,
    input  o_iter_idx,
    input  o_busy,
    input  o_done,
    input  o_status
  );

endinterface

// File: rtl/ss_step_watchdog.sv
// Per-step wait counter: flags expiry when the step has waited TIMEOUT_CYC cycles without ack.
module ss_step_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TMO_W       = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  if (TIMEOUT_CYC == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{i_clk, i_rst_n, i_clr, i_en};
    assign o_expired     = 1'b0;
  end else begin : g_on
    localparam logic [TMO_W-1:0] LastCnt = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_q <= '0;
      end else if (i_clr) begin
        cnt_q <= '0;
      end else if (i_en && (cnt_q != LastCnt)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    // Expiry is flagged in the cycle whose closing edge would be the TIMEOUT_CYC-th unacked one.
    assign o_expired = i_en && (cnt_q == LastCnt);
  end

endmodule

// File: rtl/ss_iter_sequencer.sv
// Runs NUM_ITER req/ack datapath steps per start, with per-step watchdog, abort and latched status.
module ss_iter_sequencer
  import ss_seq_pkg::*;
#(
  parameter int unsigned NUM_ITER    = 24,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned IDX_W       = min1_clog2(NUM_ITER),
  parameter int unsigned TMO_W       = min1_clog2(TIMEOUT_CYC + 1)
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  ss_iter_sequencer_if.master bus
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_ITER - 1);

  ss_seq_state_e    state_q;
  logic [IDX_W-1:0] idx_q;
  ss_seq_status_e   status_q;
  logic             wdg_clr;
  logic             wdg_en;
  logic             wdg_expired;

  // Counter restarts on every ack and is held at zero outside REQ, so REQ entry starts fresh.
  assign wdg_en  = (state_q == REQ);
  assign wdg_clr = (state_q != REQ) || bus.i_step_ack;

  ss_step_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMO_W       (TMO_W)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (wdg_clr),
    .i_en      (wdg_en),
    .o_expired (wdg_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      status_q <= ST_OK;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.i_start) begin
            state_q  <= LOAD;
            idx_q    <= '0;
            status_q <= ST_OK;
          end
        end
        LOAD: begin
          if (bus.i_abort) begin
            state_q  <= DONE;
            status_q <= ST_ABORT;
          end else begin
            state_q <= REQ;
          end
        end
        REQ: begin
          // Priority: abort, then ack, then watchdog expiry.
          if (bus.i_abort) begin
            state_q  <= DONE;
            status_q <= ST_ABORT;
          end else if (bus.i_step_ack) begin
            if (idx_q == LastIdx) begin
              state_q  <= DONE;
              status_q <= ST_OK;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else if (wdg_expired) begin
            state_q  <= DONE;
            status_q <= ST_TMO;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode the state register directly; no input reaches an output combinationally.
  assign bus.o_load     = (state_q == LOAD);
  assign bus.o_step_req = (state_q == REQ);
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_done     = (state_q == DONE);
  assign bus.o_iter_idx = idx_q;
  assign bus.o_status   = status_q;

endmodule

// File: tb/tb_ss_iter_sequencer.sv
// Directed bench for ss_iter_sequencer (NUM_ITER=4, TIMEOUT_CYC=5) with a small start-detector model.
module tb_ss_iter_sequencer;

  localparam int unsigned NumIter = 4;
  localparam int unsigned TmoCyc  = 5;

  logic clk;
  logic rst_n;
  logic start_drv;
  logic abort_drv;
  logic ack_drv;
  logic use_det;
  logic det_pulse;
  logic det_q;
  int   n_total;
  int   n_bad;
  int   cyc;

  ss_iter_sequencer_if #(.IDX_W(2)) bus ();

  ss_iter_sequencer #(
    .NUM_ITER    (NumIter),
    .TIMEOUT_CYC (TmoCyc)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  assign bus.i_start    = use_det ? det_q : start_drv;
  assign bus.i_abort    = abort_drv;
  assign bus.i_step_ack = ack_drv;

  // Start detector model: pulse sets the held level, the sequencer's done pulse clears it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         det_q <= 1'b0;
    else if (det_pulse) det_q <= 1'b1;
    else if (bus.o_done) det_q <= 1'b0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  typedef struct {
    int start, abort, ack;
    int load, req, idx, busy, done, status;
  } vec_t;

  vec_t vecs[18];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic chk_outs(input string p, input int load, input int req, input int idx,
                          input int busy, input int done, input int status);
    chk({p, ".load"},   32'(bus.o_load),     load);
    chk({p, ".req"},    32'(bus.o_step_req), req);
    chk({p, ".idx"},    32'(bus.o_iter_idx), idx);
    chk({p, ".busy"},   32'(bus.o_busy),     busy);
    chk({p, ".done"},   32'(bus.o_done),     done);
    chk({p, ".status"}, 32'(bus.o_status),   status);
  endtask

  initial begin
    int acks, dones, loads, first_done, second_done, k;
    logic got_done;
    n_total = 0; n_bad = 0; cyc = 0;
    rst_n = 1'b0; start_drv = 1'b0; abort_drv = 1'b0; ack_drv = 1'b0;
    use_det = 1'b0; det_pulse = 1'b0;

    //              st ab ak  ld rq ix bz dn st
    vecs[0]  = '{1, 0, 1,  1, 0, 0, 1, 0, 0};  // start -> LOAD
    vecs[1]  = '{0, 0, 1,  0, 1, 0, 1, 0, 0};  // ack in LOAD ignored
    vecs[2]  = '{0, 0, 1,  0, 1, 1, 1, 0, 0};
    vecs[3]  = '{0, 0, 1,  0, 1, 2, 1, 0, 0};
    vecs[4]  = '{0, 0, 1,  0, 1, 3, 1, 0, 0};
    vecs[5]  = '{0, 0, 1,  0, 0, 3, 1, 1, 0};  // last ack -> DONE
    vecs[6]  = '{0, 0, 1,  0, 0, 3, 0, 0, 0};  // idx holds in IDLE
    vecs[7]  = '{1, 0, 0,  1, 0, 0, 1, 0, 0};
    vecs[8]  = '{0, 0, 0,  0, 1, 0, 1, 0, 0};
    vecs[9]  = '{0, 0, 1,  0, 1, 1, 1, 0, 0};
    vecs[10] = '{0, 0, 1,  0, 1, 2, 1, 0, 0};
    vecs[11] = '{0, 1, 1,  0, 0, 2, 1, 1, 2};  // abort beats ack
    vecs[12] = '{0, 0, 0,  0, 0, 2, 0, 0, 2};
    vecs[13] = '{0, 1, 0,  0, 0, 2, 0, 0, 2};  // abort in IDLE ignored
    vecs[14] = '{1, 1, 0,  1, 0, 0, 1, 0, 0};  // start beats abort in IDLE
    vecs[15] = '{0, 1, 0,  0, 0, 0, 1, 1, 2};  // abort in LOAD
    vecs[16] = '{0, 1, 0,  0, 0, 0, 0, 0, 2};  // abort in DONE ignored
    vecs[17] = '{0, 0, 1,  0, 0, 0, 0, 0, 2};  // ack in IDLE ignored

    #2;
    chk_outs("reset", 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      start_drv = (vecs[i].start != 0);
      abort_drv = (vecs[i].abort != 0);
      ack_drv   = (vecs[i].ack != 0);
      step();
      chk_outs($sformatf("v%0d", i), vecs[i].load, vecs[i].req, vecs[i].idx,
               vecs[i].busy, vecs[i].done, vecs[i].status);
    end
    start_drv = 1'b0; abort_drv = 1'b0; ack_drv = 1'b0;

    // Stalled acks: ack every third cycle.
    start_drv = 1'b1;
    step();
    start_drv = 1'b0;
    acks = 0; dones = 0;
    for (k = 0; k < 40; k++) begin
      ack_drv = (k % 3 == 2);
      step();
      if (ack_drv) acks++;
      if (acks < 4) begin
        chk($sformatf("stall.req%0d", k), 32'(bus.o_step_req), 1);
        chk($sformatf("stall.idx%0d", k), 32'(bus.o_iter_idx), 32'(acks));
      end else begin
        break;
      end
    end
    ack_drv = 1'b0;
    chk("stall.done", 32'(bus.o_done), 1);
    chk("stall.status", 32'(bus.o_status), 0);
    for (int j = 0; j < 4; j++) begin
      step();
      if (bus.o_done) dones++;
    end
    chk("stall.extra_done", 32'(dones), 0);

    // Timeout: no ack after LOAD.
    start_drv = 1'b1;
    step();
    start_drv = 1'b0;
    step();
    chk("tmo.entry_req", 32'(bus.o_step_req), 1);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk($sformatf("tmo.wait%0d", j), 32'(bus.o_done), 0);
    end
    step();
    chk_outs("tmo.done", 0, 0, 0, 1, 1, 1);
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("tmo.held%0d", j), 32'(bus.o_status), 1);
    end
    start_drv = 1'b1;
    step();
    start_drv = 1'b0;
    chk("tmo.cleared", 32'(bus.o_status), 0);

    // Ack arriving in the cycle the watchdog would expire wins.
    step();
    for (int j = 1; j <= 4; j++) step();
    ack_drv = 1'b1;
    step();
    ack_drv = 1'b0;
    chk_outs("tmo.ackwin", 0, 1, 1, 1, 0, 0);
    for (int j = 1; j <= 4; j++) begin
      step();
      chk($sformatf("tmo.rewait%0d", j), 32'(bus.o_done), 0);
    end
    step();
    chk_outs("tmo.done2", 0, 0, 1, 1, 1, 1);
    step();

    // Reset mid-operation.
    start_drv = 1'b1;
    step();
    start_drv = 1'b0;
    ack_drv = 1'b1;
    step();
    step();
    chk("rst.pre_idx", 32'(bus.o_iter_idx), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("rst.async", 0, 0, 0, 0, 0, 0);
    step();
    chk("rst.held_done", 32'(bus.o_done), 0);
    rst_n = 1'b1;
    step();
    chk_outs("rst.idle", 0, 0, 0, 0, 0, 0);
    ack_drv = 1'b0;
    start_drv = 1'b1;
    step();
    start_drv = 1'b0;
    chk_outs("rst.load", 1, 0, 0, 1, 0, 0);
    ack_drv = 1'b1;
    step();
    chk_outs("rst.req0", 0, 1, 0, 1, 0, 0);
    got_done = 1'b0;
    for (int j = 0; j < 10 && !got_done; j++) begin
      step();
      got_done = bus.o_done;
    end
    chk("rst.op_done", 32'(got_done), 1);
    chk("rst.op_status", 32'(bus.o_status), 0);
    step();

    // Detector loop: one pulse gives exactly one op.
    use_det = 1'b1;
    det_pulse = 1'b1;
    step();
    det_pulse = 1'b0;
    loads = 0; dones = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (bus.o_load) loads++;
      if (bus.o_done) dones++;
    end
    chk("det.loads", 32'(loads), 1);
    chk("det.dones", 32'(dones), 1);
    chk("det.start_clear", 32'(det_q), 0);

    // Held detector start: back-to-back ops, NUM_ITER+3 cycles apart.
    det_pulse = 1'b1;
    first_done = -1; second_done = -1;
    for (int j = 0; j < 40 && second_done < 0; j++) begin
      step();
      if (bus.o_done) begin
        if (first_done < 0) first_done = cyc;
        else second_done = cyc;
      end
    end
    det_pulse = 1'b0;
    chk("det.b2b_seen", 32'(second_done >= 0), 1);
    chk("det.b2b_gap", 32'(second_done - first_done), NumIter + 3);
    for (int j = 0; j < 20; j++) step();
    chk("det.drain_busy", 32'(bus.o_busy), 0);
    chk("det.drain_start", 32'(det_q), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
